// File: rtl/register_file.sv
// rtl/register_file.sv - integer register file with write-through bypass and per-register RAW hazard scoreboard
module register_file #(
    parameter int XLEN      = 32,
    parameter int REGS      = 32,
    parameter int PENDING_W = 2,
    localparam int AW       = $clog2(REGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   reg_a_1,
    input  logic [AW-1:0]   reg_a_2,
    output logic [XLEN-1:0] reg_rd1,
    output logic [XLEN-1:0] reg_rd2,
    output logic            reg_1_busy,
    output logic            reg_2_busy,
    input  logic [AW-1:0]   reg_a_write,
    input  logic            reg_we,
    input  logic [XLEN-1:0] reg_write,
    input  logic            issue_valid,
    input  logic            issue_reg_we,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_full,
    output logic            sb_error
);
    localparam logic [PENDING_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]      regs [REGS];
    logic [PENDING_W-1:0] cnt  [REGS];

    logic inc_any, dec_any, same_reg, err_set;
    logic dec_1, dec_2;

    assign inc_any  = issue_valid && issue_reg_we && (issue_rd != '0);
    assign dec_any  = reg_we && (reg_a_write != '0);
    assign same_reg = (issue_rd == reg_a_write);

    assign dec_1 = dec_any && (reg_a_write == reg_a_1);
    assign dec_2 = dec_any && (reg_a_write == reg_a_2);

    assign reg_rd1 = (reg_a_1 == '0) ? '0 : dec_1 ? reg_write : regs[reg_a_1];
    assign reg_rd2 = (reg_a_2 == '0) ? '0 : dec_2 ? reg_write : regs[reg_a_2];

    // Retiring producer is discounted so decode sees the bypassed value as ready
    assign reg_1_busy = (reg_a_1 != '0) && ((cnt[reg_a_1] - PENDING_W'(dec_1)) != '0);
    assign reg_2_busy = (reg_a_2 != '0) && ((cnt[reg_a_2] - PENDING_W'(dec_2)) != '0);

    assign issue_full = (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX)
                        && !(dec_any && same_reg);

    // Simultaneous issue and retire of one register cancel out, even at the limits
    assign err_set = (inc_any && !(dec_any && same_reg) && (cnt[issue_rd] == CNT_MAX))
                  || (dec_any && !(inc_any && same_reg) && (cnt[reg_a_write] == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else if (dec_any) begin
            regs[reg_a_write] <= reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) cnt[i] <= '0;
        end else begin
            for (int r = 1; r < REGS; r++) begin
                if (inc_any && (issue_rd == AW'(r)) && !(dec_any && same_reg)
                    && (cnt[r] != CNT_MAX))
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec_any && (reg_a_write == AW'(r)) && !(inc_any && same_reg)
                    && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_error <= 1'b0;
        else if (err_set)
            sb_error <= 1'b1;
    end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file against a counting reference model
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  a1, a2, aw, ir;
    logic        we, iv, iwe;
    logic [31:0] wd;
    logic [31:0] rd1, rd2;
    logic        b1, b2, full, err;

    register_file dut (
        .clk(clk), .rst_n(rst_n),
        .reg_a_1(a1), .reg_a_2(a2), .reg_rd1(rd1), .reg_rd2(rd2),
        .reg_1_busy(b1), .reg_2_busy(b2),
        .reg_a_write(aw), .reg_we(we), .reg_write(wd),
        .issue_valid(iv), .issue_reg_we(iwe), .issue_rd(ir),
        .issue_full(full), .sb_error(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rd1, rd2;
        logic        b1, b2, full, err;
    } exp_t;

    exp_t        q[$];
    int          id_ctr = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mregs [32];
    int          mcnt  [32];
    bit          merr;

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'h0;
            mcnt[i]  = 0;
        end
        merr = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we && aw == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        int pend;
        pend = mcnt[a] - ((we && aw == a) ? 1 : 0);
        return (a != 0) && (pend != 0);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.id   = id_ctr;
        e.rd1  = m_read(a1);
        e.rd2  = m_read(a2);
        e.b1   = m_busy(a1);
        e.b2   = m_busy(a2);
        e.full = (ir != 0) && (mcnt[ir] == 3) && !(we && aw == ir);
        e.err  = merr;
        return e;
    endfunction

    function automatic void model_step();
        bit inc, dec;
        inc = iv && iwe && ir != 0;
        dec = we && aw != 0;
        if (dec) mregs[aw] = wd;
        if (inc && dec && ir == aw) return;
        if (inc) begin
            if (mcnt[ir] == 3) merr = 1'b1;
            else mcnt[ir]++;
        end
        if (dec) begin
            if (mcnt[aw] == 0) merr = 1'b1;
            else mcnt[aw]--;
        end
    endfunction

    task automatic drive(input logic [4:0] t_a1, input logic [4:0] t_a2, input logic t_we,
                         input logic [4:0] t_aw, input logic [31:0] t_wd,
                         input logic t_iv, input logic t_iwe, input logic [4:0] t_ir);
        @(posedge clk);
        #1;
        a1 = t_a1; a2 = t_a2; we = t_we; aw = t_aw; wd = t_wd;
        iv = t_iv; iwe = t_iwe; ir = t_ir;
        q.push_back(predict());
        id_ctr++;
        model_step();
    endtask

    task automatic idle_inputs();
        a1 = 0; a2 = 0; we = 0; aw = 0; wd = 0; iv = 0; iwe = 0; ir = 0;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // Reset lands between edges; the following negedge check sees it before any clock edge
    task automatic reset_mid(input logic [4:0] probe);
        @(posedge clk);
        #1;
        idle_inputs();
        a1 = probe; a2 = probe;
        #1 rst_n = 1'b0;
        model_clear();
        q.push_back(predict());
        id_ctr++;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic check(input string name, input int id, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s id=%0d got=%h want=%h", name, id, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("rd1",  e.id, rd1, e.rd1);
            check("rd2",  e.id, rd2, e.rd2);
            check("busy1", e.id, 32'(b1), 32'(e.b1));
            check("busy2", e.id, 32'(b2), 32'(e.b2));
            check("full", e.id, 32'(full), 32'(e.full));
            check("sb_error", e.id, 32'(err), 32'(e.err));
        end
    end

    initial begin
        logic [4:0] pend [$];
        logic [4:0] r_aw, r_ir;
        logic       r_we, r_iv;
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        for (int i = 0; i < 32; i++) drive(5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 1, 1, 5);
        drive(5, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        drive(5, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 32'h1234, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 1, 1, 7);
        drive(0, 0, 0, 0, 0, 1, 1, 7);
        drive(7, 7, 0, 0, 0, 0, 0, 0);
        drive(7, 0, 1, 7, 32'h1111, 0, 0, 0);
        drive(7, 0, 1, 7, 32'h2222, 0, 0, 0);
        drive(7, 7, 0, 0, 0, 0, 0, 0);

        repeat (3) drive(0, 0, 0, 0, 0, 1, 1, 3);
        drive(3, 0, 0, 0, 0, 0, 0, 3);
        drive(3, 0, 1, 3, 32'h3333, 1, 1, 3);
        drive(3, 0, 0, 0, 0, 0, 0, 3);
        drive(0, 3, 0, 0, 0, 1, 1, 3);
        drive(3, 0, 0, 0, 0, 0, 0, 3);

        reset_pulse();
        drive(0, 0, 1, 9, 32'h9999, 0, 0, 0);
        drive(9, 0, 0, 0, 0, 0, 0, 9);

        drive(0, 0, 0, 0, 0, 1, 1, 4);
        drive(0, 0, 0, 0, 0, 1, 1, 4);
        drive(4, 0, 1, 4, 32'h55, 0, 0, 0);
        drive(4, 4, 0, 0, 0, 0, 0, 4);
        reset_mid(4);
        drive(4, 4, 0, 0, 0, 0, 0, 4);

        for (int n = 0; n < 400; n++) begin
            pend.delete();
            for (int r = 1; r < 8; r++) if (mcnt[r] > 0) pend.push_back(5'(r));
            r_we = 0;
            r_aw = 5'($urandom_range(0, 7));
            if (pend.size() != 0 && $urandom_range(0, 1) == 1) begin
                r_we = 1;
                r_aw = pend[$urandom_range(0, pend.size() - 1)];
            end else if ($urandom_range(0, 3) == 0) begin
                r_we = 1;
                r_aw = 0;
            end
            r_ir = 5'($urandom_range(0, 7));
            r_iv = $urandom_range(0, 1) == 1;
            if (mcnt[r_ir] == 3 && !(r_we && r_aw == r_ir)) r_iv = 0;
            drive(($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), r_we, r_aw, $urandom, r_iv,
                  $urandom_range(0, 3) != 0, r_ir);
        end

        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
